// File: rtl/deaggregator.sv
// -----------------------------------------------------------------------------
// deaggregator
//
// Write-side serializer in the wclk domain. Accepts one wide word holding up
// to FETCH_WIDTH packed DATA_WIDTH-bit elements and pushes the first fw of
// them, element 0 first, one per cycle into a SyncFIFO enqueue port. It is the
// transmit-side counterpart of the aggregator, and its runtime fetch-width
// interface matches the aggregator's, so both ends are configured identically.
//
// Ports:
//   wclk                clock
//   wrst_n              synchronous active-low reset
//   in_data             packed wide word, element 0 in bits [DATA_WIDTH-1:0]
//   in_valid            in_data valid
//   in_ready            word accepted this cycle (combinational)
//   change_fetch_width  load input_fetch_width (honoured only when idle)
//   input_fetch_width   elements per wide word (0 ignored, clamped to max)
//   fifo_full_n         FIFO not full
//   fifo_enq            FIFO enqueue strobe (combinational)
//   fifo_data           FIFO write data
//   busy                serialization in progress
// -----------------------------------------------------------------------------
module deaggregator #(
  parameter int DATA_WIDTH  = 11,
  parameter int FETCH_WIDTH = 6,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                              wclk,
  input  logic                              wrst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              change_fetch_width,
  input  logic [COUNT_WIDTH-1:0]            input_fetch_width,
  input  logic                              fifo_full_n,
  output logic                              fifo_enq,
  output logic [DATA_WIDTH-1:0]             fifo_data,
  output logic                              busy
);

  localparam int                     WORD_W = FETCH_WIDTH * DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] FW_MAX = COUNT_WIDTH'(FETCH_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_W-1:0]      shreg_q, shreg_d;
  logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic [COUNT_WIDTH-1:0] fw_q,    fw_d;

  logic last_elem;
  logic accept;

  // fw_q is never 0, so fw_q - 1 cannot wrap.
  assign last_elem = (cnt_q == fw_q - ONE);

  // Both strobes are gated by reset so nothing is enqueued or accepted in a
  // reset cycle. in_ready never looks at in_valid, which keeps in_valid off
  // any combinational path to fifo_enq.
  assign fifo_enq  = wrst_n && (state_q == SEND) && fifo_full_n;
  assign in_ready  = wrst_n && ((state_q == IDLE) || (last_elem && fifo_enq));
  assign accept    = in_valid && in_ready;
  assign fifo_data = shreg_q[DATA_WIDTH-1:0];
  assign busy      = (state_q == SEND);

  always_comb begin
    // NOTE: every signal gets a hold default first, so no path through this
    // block can leave one unassigned and infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    fw_d    = fw_q;

    // A width change in SEND is dropped, not queued. Because fw_q only
    // matters in SEND, loading it on the accept edge makes the new width
    // apply to the word accepted in the same cycle.
    if (state_q == IDLE && change_fetch_width && input_fetch_width != '0) begin
      fw_d = (input_fetch_width > FW_MAX) ? FW_MAX : input_fetch_width;
    end

    // An accept in SEND can only coincide with the final enqueue, so it
    // takes priority and reloads the shifter with no bubble.
    if (accept) begin
      shreg_d = in_data;
      cnt_d   = '0;
      state_d = SEND;
    end else if (fifo_enq) begin
      shreg_d = shreg_q >> DATA_WIDTH;
      cnt_d   = cnt_q + ONE;
      if (last_elem) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge wclk) begin
    // NOTE: the datapath shift register is reset too, so fifo_data reads 0
    // after reset rather than stale contents.
    if (!wrst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      fw_q    <= FW_MAX;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      fw_q    <= fw_d;
    end
  end

endmodule

// File: tb/tb_deaggregator.sv
// -----------------------------------------------------------------------------
// tb_deaggregator
//
// Directed self-checking bench for deaggregator (DATA_WIDTH=11, FETCH_WIDTH=6,
// COUNT_WIDTH=3). Inputs change 1 time unit after a rising edge and outputs
// are sampled 1 unit later; a monitor on the falling edge records every
// enqueued element into a queue for order and count checks.
// -----------------------------------------------------------------------------
module tb_deaggregator;

  localparam int DW = 11;
  localparam int FW = 6;
  localparam int CW = 3;
  localparam int W  = FW * DW;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          change_fetch_width;
  logic [CW-1:0] input_fetch_width;
  logic          fifo_full_n;
  logic          fifo_enq;
  logic [DW-1:0] fifo_data;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int enq_q[$];

  deaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .COUNT_WIDTH(CW)) dut (
    .wclk               (wclk),
    .wrst_n             (wrst_n),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width),
    .fifo_full_n        (fifo_full_n),
    .fifo_enq           (fifo_enq),
    .fifo_data          (fifo_data),
    .busy               (busy)
  );

  always #5 wclk = ~wclk;

  always @(negedge wclk) begin
    if (fifo_enq) enq_q.push_back(int'(fifo_data));
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Element i = base + step*i.
  function automatic logic [W-1:0] pack(input int base, input int step);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < FW; i++) w[i*DW +: DW] = DW'(base + step * i);
    return w;
  endfunction

  // Set the fetch width while idle (one cycle pulse).
  task automatic set_fw(input int v);
    change_fetch_width = 1'b1;
    input_fetch_width  = CW'(v);
    tick();
    change_fetch_width = 1'b0;
  endtask

  // Offer one word (with whatever change_fetch_width is already driven),
  // then run a bounded number of cycles and report how many enqueues took
  // place. With chg_mid, a width change to 2 is pulsed during SEND.
  task automatic run_word(input logic [W-1:0] w, input bit chg_mid, output int n);
    enq_q.delete();
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid           = 1'b0;
    change_fetch_width = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (chg_mid) begin
        change_fetch_width = (c < 3);
        input_fetch_width  = CW'(2);
      end
      tick();
    end
    change_fetch_width = 1'b0;
    n = enq_q.size();
  endtask

  initial begin
    int n;
    logic [13:0] rdy_mask, enq_mask;

    wrst_n             = 1'b0;
    in_data            = pack(100, 1);
    in_valid           = 1'b1;
    change_fetch_width = 1'b0;
    input_fetch_width  = '0;
    fifo_full_n        = 1'b1;

    // ---- reset: strobes gated low while wrst_n is low ----
    tick();
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_fifo_enq", int'(fifo_enq), 0);
    tick();
    wrst_n   = 1'b1;
    in_valid = 1'b0;
    #1;
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_enq", int'(fifo_enq), 0);
    check("post_rst_ready", int'(in_ready), 1);
    check("post_rst_data", int'(fifo_data), 0);
    tick();

    // ---- default width is 6 ----
    run_word(pack(21, 1), 1'b0, n);
    check("default_fw_count", n, 6);
    for (int i = 0; i < 6 && i < enq_q.size(); i++) check("default_fw_elem", enq_q[i], 21 + i);

    // ---- fw=2: elements 3 then 5, upper elements not sent ----
    set_fw(2);
    enq_q.delete();
    in_data  = pack(3, 2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("fw2_enq0", int'(fifo_enq), 1);
    check("fw2_data0", int'(fifo_data), 3);
    check("fw2_busy", int'(busy), 1);
    tick();
    #1;
    check("fw2_enq1", int'(fifo_enq), 1);
    check("fw2_data1", int'(fifo_data), 5);
    check("fw2_last_ready", int'(in_ready), 1);
    tick();
    #1;
    check("fw2_idle_busy", int'(busy), 0);
    check("fw2_idle_enq", int'(fifo_enq), 0);
    check("fw2_count", enq_q.size(), 2);

    // ---- fw=6 back-to-back: 12 consecutive enqueues, 1..12 ----
    set_fw(6);
    enq_q.delete();
    rdy_mask = '0;
    enq_mask = '0;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c <= 6);
      in_data  = (c == 0) ? pack(1, 1) : pack(7, 1);
      #1;
      rdy_mask[c] = in_ready;
      enq_mask[c] = fifo_enq;
      tick();
    end
    in_valid = 1'b0;
    check("b2b_ready_mask", int'(rdy_mask[11:0]), 'h041);
    check("b2b_enq_mask", int'(enq_mask), 'h1ffe);
    check("b2b_count", enq_q.size(), 12);
    for (int i = 0; i < 12 && i < enq_q.size(); i++) check("b2b_elem", enq_q[i], i + 1);

    // ---- fw=2 with FIFO full for 3 cycles after first enqueue ----
    set_fw(2);
    enq_q.delete();
    in_data  = pack(3, 2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("full_first_data", int'(fifo_data), 3);
    tick();
    fifo_full_n = 1'b0;
    in_valid    = 1'b1;
    in_data     = pack(40, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("full_hold_enq", int'(fifo_enq), 0);
      check("full_hold_data", int'(fifo_data), 5);
      check("full_hold_ready", int'(in_ready), 0);
      tick();
    end
    fifo_full_n = 1'b1;
    in_valid    = 1'b0;
    #1;
    check("full_release_enq", int'(fifo_enq), 1);
    check("full_release_data", int'(fifo_data), 5);
    tick();
    tick();
    check("full_count", enq_q.size(), 2);
    if (enq_q.size() == 2) begin
      check("full_elem0", enq_q[0], 3);
      check("full_elem1", enq_q[1], 5);
    end

    // ---- width updates: clamp, ignore 0, coincide with accept, in SEND ----
    set_fw(7);
    run_word(pack(50, 1), 1'b0, n);
    check("fw_clamp_7", n, 6);
    set_fw(0);
    run_word(pack(60, 1), 1'b0, n);
    check("fw_zero_ignored", n, 6);
    change_fetch_width = 1'b1;
    input_fetch_width  = CW'(3);
    run_word(pack(70, 1), 1'b0, n);
    check("fw_with_accept", n, 3);
    set_fw(6);
    run_word(pack(80, 1), 1'b1, n);
    check("fw_in_send_cur", n, 6);
    run_word(pack(90, 1), 1'b0, n);
    check("fw_in_send_next", n, 6);

    // ---- reset after 2 of 6 elements ----
    set_fw(2);
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;
    enq_q.delete();
    in_data  = pack(21, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    wrst_n = 1'b0;
    #1;
    check("mid_rst_enq", int'(fifo_enq), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    tick();
    wrst_n = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_sent", enq_q.size(), 2);
    tick();
    run_word(pack(31, 1), 1'b0, n);
    check("after_rst_count", n, 6);
    if (enq_q.size() > 0) check("after_rst_first", enq_q[0], 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
